// File: rtl/mem_stage.sv
// Memory stage of the five-stage MIPS pipeline: E/M register, lw/sw decode, word-addressed data memory.
// Optional store tracing is compiled in when DM_DISPLAY_EN is defined.
module mem_stage #(
    parameter int DM_WORDS = 3072,
    parameter int DM_AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_M,
    input  logic [31:0] result_E_i,
    input  logic [4:0]  A2_E_i,
    input  logic [31:0] RD2_E_i,
    input  logic [31:0] PCn_E_i,
    input  logic        regWrite_E_i,
    input  logic [4:0]  A3_E_i,
    input  logic [31:0] OP_E_i,
    input  logic        WD_sel_M,
    input  logic [31:0] W_forward,
    output logic [31:0] M_result,
    output logic [4:0]  A2_M_o,
    output logic [4:0]  A3_M_o,
    output logic        regWrite_M_o,
    output logic [31:0] DM_RD_M_o,
    output logic [31:0] PCn_M_o,
    output logic [31:0] OP_M_o
);

    localparam logic [5:0]     OPC_LW   = 6'b100011;
    localparam logic [5:0]     OPC_SW   = 6'b101011;
    localparam logic [DM_AW:0] DM_LIMIT = (DM_AW + 1)'(DM_WORDS);

    // E/M pipeline register fields
    logic [31:0] result_m;
    logic [4:0]  a2_m;
    logic [31:0] rd2_m;
    logic [31:0] pcn_m;
    logic        reg_write_m;
    logic [4:0]  a3_m;
    logic [31:0] op_m;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_m    <= '0;
            a2_m        <= '0;
            rd2_m       <= '0;
            pcn_m       <= '0;
            reg_write_m <= 1'b0;
            a3_m        <= '0;
            op_m        <= '0;
        end else if (flush_M) begin
            result_m    <= '0;
            a2_m        <= '0;
            rd2_m       <= '0;
            pcn_m       <= '0;
            reg_write_m <= 1'b0;
            a3_m        <= '0;
            op_m        <= '0;
        end else begin
            result_m    <= result_E_i;
            a2_m        <= A2_E_i;
            rd2_m       <= RD2_E_i;
            pcn_m       <= PCn_E_i;
            reg_write_m <= regWrite_E_i;
            a3_m        <= A3_E_i;
            op_m        <= OP_E_i;
        end
    end

    // Decode and address generation for the instruction sitting in M
    logic             is_lw;
    logic             is_sw;
    logic [DM_AW-1:0] dm_idx;
    logic             in_range;
    logic [31:0]      store_data;
    logic             dm_we;

    assign is_lw      = (op_m[31:26] == OPC_LW);
    assign is_sw      = (op_m[31:26] == OPC_SW);
    assign dm_idx     = result_m[DM_AW+1:2];
    assign in_range   = ({1'b0, dm_idx} < DM_LIMIT);
    // A lw in W feeding this sw's data is resolved here rather than stalling.
    assign store_data = WD_sel_M ? W_forward : rd2_m;
    assign dm_we      = is_sw && in_range;

    // Data memory: cleared by reset, so an in-flight store is dropped while reset is low.
    logic [31:0] dm [DM_WORDS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm[i] <= '0;
            end
        end else if (dm_we) begin
            dm[dm_idx] <= store_data;
        end
    end

    // Combinational read sees the pre-write value within the write cycle.
    logic [31:0] dm_rd;

    always_comb begin
        dm_rd = '0;
        if (is_lw && in_range) begin
            dm_rd = dm[dm_idx];
        end
    end

`ifdef DM_DISPLAY_EN
    always @(posedge clk) begin
        if (reset && dm_we) begin
            $display("%d@%h: *%h <= %h", $time, pcn_m - 32'd8, result_m, store_data);
        end
    end
`else
    // Store tracing compiled out; behaviour is unchanged.
`endif

    assign M_result     = result_m;
    assign A2_M_o       = a2_m;
    assign A3_M_o       = a3_m;
    assign regWrite_M_o = reg_write_m;
    assign DM_RD_M_o    = dm_rd;
    assign PCn_M_o      = pcn_m;
    assign OP_M_o       = op_m;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: reset checks, a directed vector table, a reset-mid-store
// sequence and a randomized run against a word-array reference model.
module tb_mem_stage;

    localparam int DM_WORDS = 3072;
    localparam int DM_AW    = 12;

    logic        clk;
    logic        reset;
    logic        flush_M;
    logic [31:0] result_E_i;
    logic [4:0]  A2_E_i;
    logic [31:0] RD2_E_i;
    logic [31:0] PCn_E_i;
    logic        regWrite_E_i;
    logic [4:0]  A3_E_i;
    logic [31:0] OP_E_i;
    logic        WD_sel_M;
    logic [31:0] W_forward;
    logic [31:0] M_result;
    logic [4:0]  A2_M_o;
    logic [4:0]  A3_M_o;
    logic        regWrite_M_o;
    logic [31:0] DM_RD_M_o;
    logic [31:0] PCn_M_o;
    logic [31:0] OP_M_o;

    mem_stage #(.DM_WORDS(DM_WORDS), .DM_AW(DM_AW)) dut (
        .clk(clk), .reset(reset), .flush_M(flush_M),
        .result_E_i(result_E_i), .A2_E_i(A2_E_i), .RD2_E_i(RD2_E_i),
        .PCn_E_i(PCn_E_i), .regWrite_E_i(regWrite_E_i), .A3_E_i(A3_E_i),
        .OP_E_i(OP_E_i), .WD_sel_M(WD_sel_M), .W_forward(W_forward),
        .M_result(M_result), .A2_M_o(A2_M_o), .A3_M_o(A3_M_o),
        .regWrite_M_o(regWrite_M_o), .DM_RD_M_o(DM_RD_M_o),
        .PCn_M_o(PCn_M_o), .OP_M_o(OP_M_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [5:0] OPC_LW  = 6'b100011;
    localparam logic [5:0] OPC_SW  = 6'b101011;
    localparam logic [5:0] OPC_ADD = 6'b001000;

    function automatic logic [31:0] mk_op(input logic [5:0] opc, input logic [4:0] rt);
        return {opc, 5'd3, rt, 16'h0010};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_e(input logic [31:0] op, input logic [31:0] addr, input logic [31:0] rd2,
                           input logic [31:0] pcn, input logic flush);
        OP_E_i       = op;
        result_E_i   = addr;
        RD2_E_i      = rd2;
        PCn_E_i      = pcn;
        A2_E_i       = op[20:16];
        A3_E_i       = op[20:16] ^ 5'd7;
        regWrite_E_i = (op[31:26] == OPC_LW);
        flush_M      = flush;
    endtask

    // reference model: word array plus the instruction currently held in M
    logic [31:0] mdl [DM_WORDS];
    logic [31:0] m_res, m_op, m_rd2, m_pcn;
    logic [4:0]  m_a2, m_a3;
    logic        m_rw;

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % (1 << DM_AW));
    endfunction

    function automatic logic [31:0] model_load();
        if (m_op[31:26] == OPC_LW && widx(m_res) < DM_WORDS) return mdl[widx(m_res)];
        return 32'h0;
    endfunction

    typedef struct {
        logic [31:0] op;
        logic [31:0] addr;
        logic [31:0] rd2;
        logic        wd_sel;
        logic [31:0] wfwd;
        logic        flush;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk_vec(input logic [31:0] op, input logic [31:0] addr, input logic [31:0] rd2,
                                    input logic wd_sel, input logic [31:0] wfwd, input logic flush,
                                    input logic [31:0] exp_rd);
        vec_t v;
        v.op = op; v.addr = addr; v.rd2 = rd2; v.wd_sel = wd_sel;
        v.wfwd = wfwd; v.flush = flush; v.exp_rd = exp_rd;
        return v;
    endfunction

    initial begin
        logic [31:0] e_op, e_addr, pcn;
        logic [5:0]  opc;
        logic        fl, wsel;
        logic [31:0] wf, rd2;
        int          sel;

        reset = 1'b0;
        WD_sel_M = 1'b0;
        W_forward = 32'h0;
        drive_e(32'h0, 32'h1234, 32'h5555AAAA, 32'h400008, 1'b0);
        OP_E_i = mk_op(OPC_SW, 5'd9);
        A2_E_i = 5'd9; A3_E_i = 5'd4; regWrite_E_i = 1'b1;

        // reset: outputs stay 0 across edges while reset is low
        tick();
        tick();
        chk("rst_M_result", M_result, 32'h0);
        chk("rst_OP", OP_M_o, 32'h0);
        chk("rst_A2", {27'h0, A2_M_o}, 32'h0);
        chk("rst_A3", {27'h0, A3_M_o}, 32'h0);
        chk("rst_regWrite", {31'h0, regWrite_M_o}, 32'h0);
        chk("rst_PCn", PCn_M_o, 32'h0);

        reset = 1'b1;
        drive_e(32'h0, 32'h1234, 32'h0, 32'h0, 1'b0);
        tick();
        chk("rel_M_result", M_result, 32'h1234);
        for (int w = 0; w < 4; w++) begin
            drive_e(mk_op(OPC_LW, 5'd2), 32'(w * 4), 32'h0, 32'h0, 1'b0);
            tick();
            chk("rst_dm_clear", DM_RD_M_o, 32'h0);
        end

        // directed table; wd_sel/wfwd apply while that vector's instruction is in M
        vecs[0]  = mk_vec(mk_op(OPC_SW, 5'd1),  32'h8,    32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 32'h0);
        vecs[1]  = mk_vec(mk_op(OPC_LW, 5'd2),  32'h8,    32'h0,        1'b0, 32'h0,        1'b0, 32'hDEADBEEF);
        vecs[2]  = mk_vec(mk_op(OPC_SW, 5'd3),  32'h10,   32'h0,        1'b1, 32'hCAFE0001, 1'b0, 32'h0);
        vecs[3]  = mk_vec(mk_op(OPC_LW, 5'd4),  32'h10,   32'h0,        1'b0, 32'h0,        1'b0, 32'hCAFE0001);
        vecs[4]  = mk_vec(mk_op(OPC_SW, 5'd5),  32'hB,    32'h11112222, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0);
        vecs[5]  = mk_vec(mk_op(OPC_LW, 5'd6),  32'h8,    32'h0,        1'b0, 32'h0,        1'b0, 32'h11112222);
        vecs[6]  = mk_vec(mk_op(OPC_SW, 5'd7),  32'h3000, 32'h55555555, 1'b0, 32'h0,        1'b0, 32'h0);
        vecs[7]  = mk_vec(mk_op(OPC_LW, 5'd8),  32'h3000, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
        vecs[8]  = mk_vec(mk_op(OPC_LW, 5'd9),  32'h2FFC, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
        vecs[9]  = mk_vec(mk_op(OPC_SW, 5'd10), 32'h2FFC, 32'hAAAA5555, 1'b0, 32'h0,        1'b0, 32'h0);
        vecs[10] = mk_vec(mk_op(OPC_LW, 5'd11), 32'h2FFF, 32'h0,        1'b0, 32'h0,        1'b0, 32'hAAAA5555);
        vecs[11] = mk_vec(mk_op(OPC_SW, 5'd12), 32'h20,   32'h77777777, 1'b0, 32'h0,        1'b1, 32'h0);
        vecs[12] = mk_vec(mk_op(OPC_LW, 5'd13), 32'h20,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
        vecs[13] = mk_vec(32'h0,                32'h8,    32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
        vecs[14] = mk_vec(mk_op(OPC_LW, 5'd14), 32'h4008, 32'h0,        1'b0, 32'h0,        1'b0, 32'h11112222);

        for (int i = 0; i < 15; i++) begin
            drive_e(vecs[i].op, vecs[i].addr, vecs[i].rd2, 32'h400000 + 32'(i * 4), vecs[i].flush);
            tick();
            chk($sformatf("vec%0d_M_result", i), M_result, vecs[i].flush ? 32'h0 : vecs[i].addr);
            chk($sformatf("vec%0d_OP", i), OP_M_o, vecs[i].flush ? 32'h0 : vecs[i].op);
            chk($sformatf("vec%0d_regWrite", i), {31'h0, regWrite_M_o},
                (!vecs[i].flush && vecs[i].op[31:26] == OPC_LW) ? 32'h1 : 32'h0);
            chk($sformatf("vec%0d_PCn", i), PCn_M_o, vecs[i].flush ? 32'h0 : 32'h400000 + 32'(i * 4));
            chk($sformatf("vec%0d_DM_RD", i), DM_RD_M_o, vecs[i].exp_rd);
            WD_sel_M  = vecs[i].wd_sel;
            W_forward = vecs[i].wfwd;
        end
        WD_sel_M = 1'b0;

        // reset mid-store: sw sits in M, reset falls before its write edge
        drive_e(mk_op(OPC_SW, 5'd15), 32'h40, 32'h99999999, 32'h400100, 1'b0);
        tick();
        chk("mid_sw_in_M", OP_M_o, mk_op(OPC_SW, 5'd15));
        #2 reset = 1'b0;
        #1;
        chk("mid_async_M_result", M_result, 32'h0);
        chk("mid_async_OP", OP_M_o, 32'h0);
        tick();
        reset = 1'b1;
        drive_e(mk_op(OPC_LW, 5'd1), 32'h40, 32'h0, 32'h0, 1'b0);
        tick();
        chk("mid_store_aborted", DM_RD_M_o, 32'h0);
        drive_e(mk_op(OPC_LW, 5'd1), 32'h8, 32'h0, 32'h0, 1'b0);
        tick();
        chk("mid_dm_cleared", DM_RD_M_o, 32'h0);

        // randomized run against the model; reset has cleared memory
        for (int w = 0; w < DM_WORDS; w++) mdl[w] = 32'h0;
        m_res = 32'h8; m_op = mk_op(OPC_LW, 5'd1); m_rd2 = 32'h0; m_pcn = 32'h0;
        m_a2 = 5'd1; m_a3 = 5'd1 ^ 5'd7; m_rw = 1'b1;

        for (int c = 0; c < 400; c++) begin
            sel = $urandom_range(0, 9);
            opc = (sel < 4) ? OPC_LW : (sel < 8) ? OPC_SW : OPC_ADD;
            e_op = (sel == 8) ? 32'h0 : mk_op(opc, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 15) == 0) e_addr = $urandom;
            else if ($urandom_range(0, 7) == 0) e_addr = 32'h2FF0 + 32'($urandom_range(0, 63));
            else e_addr = 32'($urandom_range(0, 63));
            rd2  = $urandom;
            pcn  = $urandom;
            fl   = ($urandom_range(0, 7) == 0);
            wsel = $urandom_range(0, 1) == 1;
            wf   = $urandom;

            WD_sel_M  = wsel;
            W_forward = wf;
            drive_e(e_op, e_addr, rd2, pcn, fl);

            if (m_op[31:26] == OPC_SW && widx(m_res) < DM_WORDS)
                mdl[widx(m_res)] = wsel ? wf : m_rd2;
            if (fl) begin
                m_res = 0; m_op = 0; m_rd2 = 0; m_pcn = 0; m_a2 = 0; m_a3 = 0; m_rw = 0;
            end else begin
                m_res = e_addr; m_op = e_op; m_rd2 = rd2; m_pcn = pcn;
                m_a2 = e_op[20:16]; m_a3 = e_op[20:16] ^ 5'd7; m_rw = (e_op[31:26] == OPC_LW);
            end
            exp_q.push_back(model_load());

            tick();
            chk("rnd_M_result", M_result, m_res);
            chk("rnd_OP", OP_M_o, m_op);
            chk("rnd_PCn", PCn_M_o, m_pcn);
            chk("rnd_A2", {27'h0, A2_M_o}, {27'h0, m_a2});
            chk("rnd_A3", {27'h0, A3_M_o}, {27'h0, m_a3});
            chk("rnd_regWrite", {31'h0, regWrite_M_o}, {31'h0, m_rw});
            chk("rnd_DM_RD", DM_RD_M_o, exp_q.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
